booth_mul256x256_seq: RTL and testbench

- Multi-cycle sequencer that computes a 256x256 -> 512-bit unsigned product using one 256x64 booth multiplier (booth_top) four times.
- Accepts operands over a valid/ready handshake and drives booth_top's A/B ports one 64-bit B slice per cycle.
- Accumulates the shifted 320-bit partial products and returns the result over a valid/ready handshake.
- booth_top is instantiated beside this block, in the enclosing wrapper; this block only sequences it.

---
 rtl/booth_pkg.sv | 20 ++
 rtl/booth_mul256x256_seq_slice_cnt_calc.sv | 21 ++
 rtl/booth_mul256x256_seq.sv | 94 +++++++++
 tb/tb_booth_mul256x256_seq.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants and FSM encoding for the 256x256 sequenced booth multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_pkg;

  localparam int A_W     = 256;               // multiplicand width, booth_top A
  localparam int SLICE_W = 64;                // multiplier slice width, booth_top B
  localparam int NSLICE  = 4;                 // number of B slices
  localparam int BP_W    = A_W + SLICE_W;     // booth_top product width (320)
  localparam int P_W     = A_W + SLICE_W * NSLICE;  // full product width (512)
  localparam int K_W     = 2;                 // slice index width, 0..NSLICE-1
  localparam int N_W     = 3;                 // slice count width, 1..NSLICE

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul256x256_seq_slice_cnt_calc.sv
// Highest-nonzero-slice encoder: n = index of top nonzero 64-bit slice of b, plus 1, minimum 1.
// Latency: combinational.
// Backpressure: none.
module slice_cnt_calc
  import booth_pkg::*;
(
  input  logic [A_W-1:0] i_b,
  output logic [N_W-1:0] o_n
);

  // Scan upward so the highest nonzero slice wins; all-zero b still needs one pass.
  always_comb begin
    o_n = N_W'(1);
    for (int s = 0; s < NSLICE; s++) begin
      if (i_b[s*SLICE_W +: SLICE_W] != '0) begin
        o_n = N_W'(s + 1);
      end
    end
  end

endmodule

// File: rtl/booth_mul256x256_seq.sv
// Sequences one external 256x64 booth multiplier over up to four B slices to form a 256x256 product.
// Latency: out_valid rises n cycles after the accept edge (n = used B slices, 1..4).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no overlap.
module booth_mul256x256_seq
  import booth_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [A_W-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic [A_W-1:0]   mul_a,
  output logic [SLICE_W-1:0] mul_b,
  input  logic [BP_W-1:0]  mul_p
);

  state_t             r_state;
  logic [A_W-1:0]     r_a;
  logic [A_W-1:0]     r_b;
  logic [K_W-1:0]     r_k;
  logic [N_W-1:0]     r_n;
  logic [P_W-1:0]     r_acc;
  logic [P_W-1:0]     r_out_p;

  logic [N_W-1:0]     w_n;
  logic [7:0]         w_shamt;
  logic [P_W-1:0]     w_pp_shifted;
  logic [P_W-1:0]     w_sum;
  logic               w_last;

  slice_cnt_calc u_slice_cnt (
    .i_b (in_b),
    .o_n (w_n)
  );

  // Partial product of slice k lands at bit 64k; the 512-bit sum cannot overflow.
  assign w_shamt      = {r_k, 6'b0};
  assign w_pp_shifted = {{(P_W-BP_W){1'b0}}, mul_p} << w_shamt;
  assign w_sum        = r_acc + w_pp_shifted;
  assign w_last       = ({1'b0, r_k} == (r_n - N_W'(1)));

  // Multiplier drive comes straight from the operand registers; only meaningful in RUN.
  assign mul_a = r_a;
  assign mul_b = r_b[w_shamt +: SLICE_W];

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_p     = r_out_p;

  // Control FSM and accumulator: accept, run n slices, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_acc   <= '0;
      r_out_p <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_acc   <= '0;
            r_k     <= '0;
            r_n     <= w_n;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_sum;
          r_k   <= r_k + K_W'(1);
          if (w_last) begin
            r_out_p <= w_sum;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul256x256_seq.sv
// Randomized self-checking bench for booth_mul256x256_seq with a behavioural booth_top stand-in.
// Latency: n/a.
// Backpressure: exercised via held and randomized out_ready.
module tb_booth_mul256x256_seq;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [255:0]  in_a;
  logic [255:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [511:0]  out_p;
  logic [255:0]  mul_a;
  logic [63:0]   mul_b;
  logic [319:0]  mul_p;

  int checks;
  int errors;

  logic [511:0] exp_q[$];
  int           b2b_got;

  booth_mul256x256_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p)
  );

  // Stand-in for booth_top: combinational unsigned 256x64 product.
  assign mul_p = {64'b0, mul_a} * {256'b0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] model(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] wa;
    logic [511:0] wb;
    wa = {256'b0, a};
    wb = {256'b0, b};
    return wa * wb;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // Random multiplier with a random number of live slices; occasionally zero.
  function automatic logic [255:0] rand_b();
    logic [255:0] v;
    int nz;
    v  = rand256();
    nz = $urandom_range(1, 4);
    for (int s = 0; s < 4; s++) if (s >= nz) v[s*64 +: 64] = 64'd0;
    if ($urandom_range(0, 7) == 0) v = '0;
    return v;
  endfunction

  // One full transaction: accept, count latency, take the result immediately.
  task automatic do_op(input logic [255:0] a, input logic [255:0] b,
                       output int lat, output logic [511:0] p, output int mb1);
    int w;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 512'd0, 512'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = ~a;
    in_b = ~b;
    lat = 0;
    mb1 = 0;
    @(negedge clk);
    if (mul_b == 64'd1) mb1++;
    while (!out_valid && lat < 20) begin
      lat++;
      @(negedge clk);
      if (mul_b == 64'd1) mb1++;
    end
    if (!out_valid) chk("result_timeout", 512'd0, 512'd1);
    p = out_p;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int mb1;
    int w;
    logic [511:0] p;
    logic [511:0] hold;
    logic [255:0] a;
    logic [255:0] b;
    logic [511:0] e;

    checks = 0;
    errors = 0;
    b2b_got = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_a = '0;
    in_b = '0;

    // Reset state
    #12;
    chk("rst_in_ready", {511'd0, in_ready}, 512'd1);
    chk("rst_out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst_out_p", out_p, 512'd0);
    chk("rst_mul_a", {256'd0, mul_a}, 512'd0);
    chk("rst_mul_b", {448'd0, mul_b}, 512'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1 x 1
    do_op(256'd1, 256'd1, lat, p, mb1);
    chk("one_lat", 512'(lat), 512'd1);
    chk("one_p", p, 512'd1);
    chk("one_mulb_cycles", 512'(mb1), 512'd1);
    @(negedge clk);
    chk("one_in_ready_after", {511'd0, in_ready}, 512'd1);

    // Single-slice fixed vector
    a = 256'h89375212b2c2846546df998d06b97b0db1f056638484d609c0895e8112153524;
    b = {192'd0, 64'h06d7cd0d00f3e301};
    do_op(a, b, lat, p, mb1);
    chk("vec_lat", 512'(lat), 512'd1);
    chk("vec_p", p, model(a, b));

    // All ones
    a = '1;
    b = '1;
    e = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
    do_op(a, b, lat, p, mb1);
    chk("ones_lat", 512'(lat), 512'd4);
    chk("ones_p", p, e);

    // Only the top slice set
    a = rand256();
    b = 256'd1 << 192;
    do_op(a, b, lat, p, mb1);
    chk("top_lat", 512'(lat), 512'd4);
    chk("top_p", p, {256'd0, a} << 192);

    // B == 0
    a = rand256();
    do_op(a, 256'd0, lat, p, mb1);
    chk("bzero_lat", 512'(lat), 512'd1);
    chk("bzero_p", p, 512'd0);

    // A == 0 still runs all slices
    b = rand256();
    b[255:192] = 64'h8000_0000_0000_0001;
    do_op(256'd0, b, lat, p, mb1);
    chk("azero_lat", 512'(lat), 512'd4);
    chk("azero_p", p, 512'd0);

    // Back-pressure: hold out_ready low for 5 cycles
    a = rand256();
    b = {128'd0, rand256() >> 128};
    b[127] = 1'b1;
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("bp_valid", {511'd0, out_valid}, 512'd1);
    chk("bp_p", out_p, model(a, b));
    hold = out_p;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_p", out_p, hold);
      chk("bp_hold_valid", {511'd0, out_valid}, 512'd1);
      chk("bp_in_ready_low", {511'd0, in_ready}, 512'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("bp_in_ready_after", {511'd0, in_ready}, 512'd1);
    chk("bp_valid_after", {511'd0, out_valid}, 512'd0);
    chk("bp_p_kept", out_p, hold);

    // Reset mid-RUN at k == 2
    @(negedge clk);
    in_a = '1;
    in_b = '1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {511'd0, out_valid}, 512'd0);
    chk("mrst_in_ready", {511'd0, in_ready}, 512'd1);
    @(negedge clk);
    rst_n = 1'b1;
    w = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) w++;
    end
    chk("mrst_no_valid", 512'(w), 512'd0);
    chk("mrst_in_ready_after", {511'd0, in_ready}, 512'd1);
    do_op(256'd3, 256'd5, lat, p, mb1);
    chk("mrst_next_p", p, 512'd15);
    chk("mrst_next_lat", 512'(lat), 512'd1);

    // Back-to-back random stream, in_valid held, random out_ready
    fork
      begin
        int wt;
        logic [255:0] ra;
        logic [255:0] rb;
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
          ra = rand256();
          rb = rand_b();
          in_a = ra;
          in_b = rb;
          in_valid = 1'b1;
          wt = 0;
          while (!in_ready && wt < 100) begin
            @(negedge clk);
            wt++;
          end
          if (!in_ready) begin
            chk("b2b_accept_timeout", 512'd0, 512'd1);
            break;
          end
          @(posedge clk);
          exp_q.push_back(model(ra, rb));
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (b2b_got < 1000 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = ($urandom_range(0, 3) != 0);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("b2b_extra", 512'd1, 512'd0);
            else chk("b2b_p", out_p, exp_q.pop_front());
            b2b_got++;
          end
        end
        out_ready = 1'b0;
      end
    join
    chk("b2b_count", 512'(b2b_got), 512'd1000);
    chk("b2b_q_empty", 512'(exp_q.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
